// File: rtl/arm_pipe_pkg.sv
// Shared types for the 5-stage ARM pipeline controller: forwarding selects,
// data-memory wait states and the default register-address width.
package arm_pipe_pkg;

  localparam int RA_W_DEF = 4;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory wait sequencer: stalls the whole pipe for MEM_WAIT cycles per
// access, then spends one DONE cycle so the same access cannot re-trigger.
module mem_wait_fsm
  import arm_pipe_pkg::*;
#(
  parameter int MEM_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  output logic stall
);

  localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (MEM_WAIT > 0) ? CW'(MEM_WAIT - 1) : '0;
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_WAIT = WAIT;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          stall_s;

  // Next-state, wait-counter and stall decode
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    stall_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (mem_req && (MEM_WAIT > 0)) begin
          stall_s     = 1'b1;
          state_nxt_s = S_WAIT;
          cnt_nxt_s   = CNT_LOAD;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_r != '0) begin
          stall_s   = 1'b1;
          cnt_nxt_s = cnt_r - CW'(1);
        end else begin
          state_nxt_s = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt_s = S_IDLE;
      end
      default: begin
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // State and counter registers; reset aborts any access in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign stall = stall_s;

endmodule

// File: rtl/arm_pipe_ctrl.sv
// Pipeline controller for the 5-stage ARM core: freeze/flush/bubble, memory
// stall, EXE operand forwarding selects and saturating stall/flush counters.
module arm_pipe_ctrl
  import arm_pipe_pkg::*;
#(
  parameter int RA_W     = RA_W_DEF,
  parameter int FWD_EN   = 1,
  parameter int MEM_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  id_src1,
  input  logic [RA_W-1:0]  id_src2,
  input  logic             id_two_src,
  input  logic             id_src1_vld,
  input  logic [RA_W-1:0]  exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [RA_W-1:0]  mem_dest,
  input  logic             mem_wb_en,
  input  logic             mem_req,
  input  logic [RA_W-1:0]  wb_dest,
  input  logic             wb_en,
  input  logic             branch_taken,
  output logic             freeze_front,
  output logic             flush,
  output logic             bubble,
  output logic             stall_all,
  output logic [1:0]       fwd_sel1,
  output logic [1:0]       fwd_sel2,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_flush
);

  function automatic logic src_match(input logic [RA_W-1:0] s1, input logic v1,
                                     input logic [RA_W-1:0] s2, input logic v2,
                                     input logic [RA_W-1:0] dest);
    return (v1 && (s1 == dest)) || (v2 && (s2 == dest));
  endfunction

  // The MEM stage holds the younger result, so it wins over WB
  function automatic fwd_sel_e fwd_pick(input logic [RA_W-1:0] src, input logic vld);
    if (vld && mem_wb_en && (src == mem_dest)) begin
      return FWD_MEM;
    end else if (vld && wb_en && (src == wb_dest)) begin
      return FWD_WB;
    end else begin
      return FWD_REG;
    end
  endfunction

  logic            stall_s;
  logic            exe_hit_s;
  logic            mem_hit_s;
  logic            hz_s;
  logic            flush_s;
  logic            bubble_s;
  fwd_sel_e        fwd1_s;
  fwd_sel_e        fwd2_s;
  logic [RA_W-1:0] exe_src1_r;
  logic [RA_W-1:0] exe_src2_r;
  logic            exe_src1_vld_r;
  logic            exe_src2_vld_r;
  logic [CNT_W-1:0] cnt_stall_r;
  logic [CNT_W-1:0] cnt_flush_r;

  mem_wait_fsm #(.MEM_WAIT(MEM_WAIT)) u_mem_wait_fsm (
    .clk     (clk),
    .rst     (rst),
    .mem_req (mem_req),
    .stall   (stall_s)
  );

  // RAW hazard against EXE (and MEM when nothing is forwarded)
  always_comb begin
    exe_hit_s = src_match(id_src1, id_src1_vld, id_src2, id_two_src, exe_dest) && exe_wb_en;
    mem_hit_s = src_match(id_src1, id_src1_vld, id_src2, id_two_src, mem_dest) && mem_wb_en;
    if (FWD_EN != 0) begin
      hz_s = exe_hit_s && exe_mem_r_en;
    end else begin
      hz_s = exe_hit_s || mem_hit_s;
    end
  end

  // Priority: memory stall over taken branch over data hazard
  always_comb begin
    flush_s  = 1'b0;
    bubble_s = 1'b0;
    if (stall_s) begin
      flush_s  = 1'b0;
      bubble_s = 1'b0;
    end else if (branch_taken) begin
      flush_s  = 1'b1;
    end else if (hz_s) begin
      bubble_s = 1'b1;
    end else begin
      bubble_s = 1'b0;
    end
  end

  // Shadow of the ID_Reg source fields, i.e. the operands now in EXE
  always_ff @(posedge clk) begin
    if (rst) begin
      exe_src1_r     <= '0;
      exe_src2_r     <= '0;
      exe_src1_vld_r <= 1'b0;
      exe_src2_vld_r <= 1'b0;
    end else if (stall_s) begin
      exe_src1_r     <= exe_src1_r;
      exe_src2_r     <= exe_src2_r;
      exe_src1_vld_r <= exe_src1_vld_r;
      exe_src2_vld_r <= exe_src2_vld_r;
    end else if (flush_s || bubble_s) begin
      exe_src1_r     <= '0;
      exe_src2_r     <= '0;
      exe_src1_vld_r <= 1'b0;
      exe_src2_vld_r <= 1'b0;
    end else begin
      exe_src1_r     <= id_src1;
      exe_src2_r     <= id_src2;
      exe_src1_vld_r <= id_src1_vld;
      exe_src2_vld_r <= id_two_src;
    end
  end

  // EXE operand selects
  always_comb begin
    if (FWD_EN != 0) begin
      fwd1_s = fwd_pick(exe_src1_r, exe_src1_vld_r);
      fwd2_s = fwd_pick(exe_src2_r, exe_src2_vld_r);
    end else begin
      fwd1_s = FWD_REG;
      fwd2_s = FWD_REG;
    end
  end

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_stall_r <= '0;
      cnt_flush_r <= '0;
    end else begin
      if ((stall_s || bubble_s) && (cnt_stall_r != '1)) begin
        cnt_stall_r <= cnt_stall_r + CNT_W'(1);
      end else begin
        cnt_stall_r <= cnt_stall_r;
      end
      if (flush_s && (cnt_flush_r != '1)) begin
        cnt_flush_r <= cnt_flush_r + CNT_W'(1);
      end else begin
        cnt_flush_r <= cnt_flush_r;
      end
    end
  end

  assign stall_all    = stall_s;
  assign flush        = flush_s;
  assign bubble       = bubble_s;
  assign freeze_front = bubble_s;
  assign fwd_sel1     = fwd1_s;
  assign fwd_sel2     = fwd2_s;
  assign cnt_stall    = cnt_stall_r;
  assign cnt_flush    = cnt_flush_r;

endmodule

// File: tb/tb_arm_pipe_ctrl.sv
// Directed bench for arm_pipe_ctrl: forwarding build (a_), non-forwarding
// build (n_) and a single-cycle-memory build with 3-bit counters (z_).
module tb_arm_pipe_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest, wb_dest;
  logic       id_two_src, id_src1_vld, exe_wb_en, exe_mem_r_en;
  logic       mem_wb_en, mem_req, wb_en, branch_taken;

  logic        a_ff, a_fl, a_bb, a_st;
  logic [1:0]  a_f1, a_f2;
  logic [15:0] a_cs, a_cf;
  logic        n_ff, n_fl, n_bb, n_st;
  logic [1:0]  n_f1, n_f2;
  logic [15:0] n_cs, n_cf;
  logic        z_ff, z_fl, z_bb, z_st;
  logic [1:0]  z_f1, z_f2;
  logic [2:0]  z_cs, z_cf;

  arm_pipe_ctrl #(.RA_W(4), .FWD_EN(1), .MEM_WAIT(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .id_src1_vld(id_src1_vld), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .mem_req(mem_req), .wb_dest(wb_dest), .wb_en(wb_en), .branch_taken(branch_taken),
    .freeze_front(a_ff), .flush(a_fl), .bubble(a_bb), .stall_all(a_st),
    .fwd_sel1(a_f1), .fwd_sel2(a_f2), .cnt_stall(a_cs), .cnt_flush(a_cf));

  arm_pipe_ctrl #(.RA_W(4), .FWD_EN(0), .MEM_WAIT(4), .CNT_W(16)) u_nf (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .id_src1_vld(id_src1_vld), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .mem_req(mem_req), .wb_dest(wb_dest), .wb_en(wb_en), .branch_taken(branch_taken),
    .freeze_front(n_ff), .flush(n_fl), .bubble(n_bb), .stall_all(n_st),
    .fwd_sel1(n_f1), .fwd_sel2(n_f2), .cnt_stall(n_cs), .cnt_flush(n_cf));

  arm_pipe_ctrl #(.RA_W(4), .FWD_EN(1), .MEM_WAIT(0), .CNT_W(3)) u_z (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .id_src1_vld(id_src1_vld), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .mem_req(mem_req), .wb_dest(wb_dest), .wb_en(wb_en), .branch_taken(branch_taken),
    .freeze_front(z_ff), .flush(z_fl), .bubble(z_bb), .stall_all(z_st),
    .fwd_sel1(z_f1), .fwd_sel2(z_f2), .cnt_stall(z_cs), .cnt_flush(z_cf));

  typedef struct {
    logic [3:0] s1; logic v1; logic [3:0] s2; logic two;
    logic [3:0] ed; logic ewb; logic eld;
    logic [3:0] md; logic mwb;
    logic [3:0] wd; logic wwb;
    logic br;
    logic ff; logic fl; logic bb; logic [1:0] f1; logic [1:0] f2; logic nff;
  } vec_t;

  vec_t vt [16];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic clr_inputs();
    id_src1 = 4'd0; id_src2 = 4'd0; id_two_src = 1'b0; id_src1_vld = 1'b0;
    exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
    mem_dest = 4'd0; mem_wb_en = 1'b0; mem_req = 1'b0;
    wb_dest = 4'd0; wb_en = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    id_src1 = v.s1; id_src1_vld = v.v1; id_src2 = v.s2; id_two_src = v.two;
    exe_dest = v.ed; exe_wb_en = v.ewb; exe_mem_r_en = v.eld;
    mem_dest = v.md; mem_wb_en = v.mwb; mem_req = 1'b0;
    wb_dest = v.wd; wb_en = v.wwb; branch_taken = v.br;
  endtask

  initial begin
    //        s1   v1    s2    two   ed   ewb   eld   md    mwb   wd    wwb   br  | ff   fl    bb    f1    f2    nff
    vt[0]  = '{4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
    vt[1]  = '{4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
    vt[2]  = '{4'd1, 1'b1, 4'd7, 1'b1, 4'd1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1};
    vt[3]  = '{4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0, 4'd1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0};
    vt[4]  = '{4'd6, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd2, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
    vt[5]  = '{4'd9, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
    vt[6]  = '{4'd3, 1'b1, 4'd12,1'b1, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1};
    vt[7]  = '{4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0};
    vt[8]  = '{4'd4, 1'b1, 4'd4, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
    vt[9]  = '{4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd4, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 1'b0};
    vt[10] = '{4'd0, 1'b0, 4'd11,1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
    vt[11] = '{4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd11,1'b0, 4'd11,1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0};
    vt[12] = '{4'd5, 1'b0, 4'd5, 1'b1, 4'd5, 1'b1, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1};
    vt[13] = '{4'd6, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
    vt[14] = '{4'd7, 1'b1, 4'd0, 1'b0, 4'd7, 1'b0, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
    vt[15] = '{4'd7, 1'b1, 4'd0, 1'b0, 4'd7, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};

    do_reset();
    @(negedge clk);
    check("reset_outs", {a_ff, a_fl, a_bb, a_st, a_f1, a_f2}, 32'd0);
    check("reset_cnts", {a_cs, a_cf}, 32'd0);
    next_cycle();

    // Hazard / priority / forwarding vectors, applied back to back
    for (int i = 0; i < 16; i++) begin
      apply(vt[i]);
      @(negedge clk);
      check($sformatf("vec%0d_fwd", i), {a_ff, a_fl, a_bb, a_st, a_f1, a_f2},
            {vt[i].ff, vt[i].fl, vt[i].bb, 1'b0, vt[i].f1, vt[i].f2});
      check($sformatf("vec%0d_nofwd", i), {n_ff, n_fl, n_bb, n_f1, n_f2},
            {vt[i].nff, vt[i].fl, vt[i].nff, 2'd0, 2'd0});
      next_cycle();
    end
    clr_inputs();
    @(negedge clk);
    check("vec_cnt_fwd",   {a_cs, a_cf}, {16'd1, 16'd1});
    check("vec_cnt_nofwd", {n_cs, n_cf}, {16'd3, 16'd1});
    next_cycle();

    // Memory stall: access held in MEM cycles 10..20; branch pending 16..20
    do_reset();
    for (int c = 0; c < 22; c++) begin
      clr_inputs();
      mem_req      = (c >= 10 && c <= 20);
      branch_taken = (c >= 16 && c <= 20);
      @(negedge clk);
      check($sformatf("mem_c%0d", c), {a_st, a_fl, a_bb, z_st},
            {((c >= 10 && c <= 13) || (c >= 16 && c <= 19)), (c == 20), 1'b0, 1'b0});
      next_cycle();
    end
    clr_inputs();
    @(negedge clk);
    check("mem_cnts", {a_cs, a_cf}, {16'd8, 16'd1});
    check("z_cnt_flush", z_cf, 32'd5);
    next_cycle();

    // Load-use: LDR r3 in EXE, ADD r4,r3 in ID
    clr_inputs();
    id_src1 = 4'd3; id_src1_vld = 1'b1;
    exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
    @(negedge clk);
    check("lu_a", {a_ff, a_bb, n_ff}, {1'b1, 1'b1, 1'b1});
    next_cycle();
    clr_inputs();
    id_src1 = 4'd3; id_src1_vld = 1'b1;
    mem_dest = 4'd3; mem_wb_en = 1'b1;
    @(negedge clk);
    check("lu_b", {a_ff, a_bb, n_ff, a_f1}, {1'b0, 1'b0, 1'b1, 2'd0});
    next_cycle();
    clr_inputs();
    exe_dest = 4'd4; exe_wb_en = 1'b1;
    wb_dest = 4'd3; wb_en = 1'b1;
    @(negedge clk);
    check("lu_c", {a_ff, n_ff, a_f1}, {1'b0, 1'b0, 2'd2});
    next_cycle();

    // Counter saturation on the 3-bit build
    clr_inputs();
    id_src1 = 4'd1; id_src1_vld = 1'b1;
    exe_dest = 4'd1; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
    repeat (10) next_cycle();
    clr_inputs();
    @(negedge clk);
    check("z_cnt_sat", z_cs, 32'd7);
    next_cycle();

    // Reset in WAIT with two wait cycles left
    mem_req = 1'b1;
    next_cycle();
    next_cycle();
    mem_req = 1'b0;
    @(negedge clk);
    check("rst_pre_wait", a_st, 32'd1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_outs", {a_st, a_fl, a_bb, a_f1, a_f2}, 32'd0);
    check("rst_mid_cnts", {a_cs, a_cf}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("rst_mid_idle", a_st, 32'd0);
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
